// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared constants and helpers for the memory-mapped I/O bank.
//                Defines the I/O region tag, the word offsets of each
//                register in the window and the seven-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    // Upper address nibble that selects the I/O window
    localparam logic [3:0] IO_REGION      = 4'hF;

    // Word offsets (addr[4:2]) inside the I/O window
    localparam logic [2:0] IO_OFF_HEX     = 3'd0;
    localparam logic [2:0] IO_OFF_LEDR    = 3'd1;
    localparam logic [2:0] IO_OFF_LEDG    = 3'd2;
    localparam logic [2:0] IO_OFF_SW      = 3'd4;
    localparam logic [2:0] IO_OFF_KEY     = 3'd5;
    localparam logic [2:0] IO_OFF_KEYEDGE = 3'd6;

    // Hex digit to active-low segment pattern, bit 0 = segment a, bit 6 = g
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : io_debouncer
//  Description : Per-bit two-flop synchronizer followed by an optional
//                counter-based debouncer. A bit's stable value follows the
//                synchronized input only after it has differed for
//                DEBOUNCE_CYCLES consecutive cycles.
//                Build option: IO_DEBOUNCE_EN - when undefined, the stable
//                value is the synchronized value and no counters exist.
//  Ports       : clk       - clock
//                reset_n   - synchronous active-low reset
//                i_async   - asynchronous active-high inputs
//                o_stable  - debounced (or just synchronized) value
//                o_rise    - high in the cycle before o_stable rises, so the
//                            consumer can act on the same edge the rise lands
//  Revision    : 1.0 - initial release
// ============================================================================
module io_debouncer #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise
);

    if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
        $error("io_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = i_async;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             stable_q, stable_d;

        // Counter clears whenever synced agrees with stable, so any glitch
        // that returns early restarts the qualification window.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync2_q[i] != stable_q) begin
                if (cnt_q == C_CNT_LAST) begin
                    stable_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign o_stable[i] = stable_q;
        assign o_rise[i]   = stable_d & ~stable_q;
    end
`else
    assign o_stable = sync2_q;
    assign o_rise   = sync1_q & ~sync2_q;
`endif

endmodule
`default_nettype wire

// File: rtl/io_device_bank.sv
`default_nettype none
// ============================================================================
//  Module      : io_device_bank
//  Description : Memory-mapped I/O responder on the data-memory port. Holds
//                the HEX/LEDR/LEDG output registers, debounces switches and
//                keys, latches key-press edges (write-1-to-clear) and returns
//                zero-latency read data for the window addr[31:28] = 4'hF.
//                Build option: IO_DEBOUNCE_EN enables the debounce counters.
//  Ports       : clk, reset_n (sync, active-low)
//                wr_en, addr, wr_data  - store interface
//                rd_data               - combinational load data
//                sw[9:0], key[3:0]     - pads (key active-low)
//                hex0..hex3            - active-low seven-segment digits
//                ledr[9:0], ledg[7:0]  - LED registers
//  Revision    : 1.0 - initial release
// ============================================================================
module io_device_bank
    import io_pkg::*;
#(
    parameter int DATA_BIT_WIDTH  = 32,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [DATA_BIT_WIDTH-1:0] addr,
    input  logic [DATA_BIT_WIDTH-1:0] wr_data,
    output logic [DATA_BIT_WIDTH-1:0] rd_data,
    input  logic [9:0]                sw,
    input  logic [3:0]                key,
    output logic [6:0]                hex0,
    output logic [6:0]                hex1,
    output logic [6:0]                hex2,
    output logic [6:0]                hex3,
    output logic [9:0]                ledr,
    output logic [7:0]                ledg
);

    logic        w_sel;
    logic [2:0]  w_off;
    logic [9:0]  w_sw_db;
    logic [3:0]  w_key_db;
    logic [3:0]  w_key_rise;
    logic [9:0]  w_sw_rise_nc;

    logic [15:0] hex_val_q,  hex_val_d;
    logic [9:0]  ledr_q,     ledr_d;
    logic [7:0]  ledg_q,     ledg_d;
    logic [3:0]  key_edge_q, key_edge_d;

    assign w_sel = (addr[DATA_BIT_WIDTH-1 -: 4] == IO_REGION);
    assign w_off = addr[4:2];

    io_debouncer #(
        .WIDTH           (10),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_async  (sw),
        .o_stable (w_sw_db),
        .o_rise   (w_sw_rise_nc)
    );

    // Keys are inverted at the pad so "pressed" is 1 throughout the core
    io_debouncer #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_db (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_async  (~key),
        .o_stable (w_key_db),
        .o_rise   (w_key_rise)
    );

    always_comb begin
        hex_val_d  = hex_val_q;
        ledr_d     = ledr_q;
        ledg_d     = ledg_q;
        key_edge_d = key_edge_q;
        if (wr_en && w_sel) begin
            case (w_off)
                IO_OFF_HEX:     hex_val_d  = wr_data[15:0];
                IO_OFF_LEDR:    ledr_d     = wr_data[9:0];
                IO_OFF_LEDG:    ledg_d     = wr_data[7:0];
                IO_OFF_KEYEDGE: key_edge_d = key_edge_q & ~wr_data[3:0];
                default:        ;
            endcase
        end
        // Applied after the clear so a new press on the same edge survives
        key_edge_d = key_edge_d | w_key_rise;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hex_val_q  <= '0;
            ledr_q     <= '0;
            ledg_q     <= '0;
            key_edge_q <= '0;
        end else begin
            hex_val_q  <= hex_val_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            key_edge_q <= key_edge_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (w_sel) begin
            case (w_off)
                IO_OFF_HEX:     rd_data = DATA_BIT_WIDTH'(hex_val_q);
                IO_OFF_LEDR:    rd_data = DATA_BIT_WIDTH'(ledr_q);
                IO_OFF_LEDG:    rd_data = DATA_BIT_WIDTH'(ledg_q);
                IO_OFF_SW:      rd_data = DATA_BIT_WIDTH'(w_sw_db);
                IO_OFF_KEY:     rd_data = DATA_BIT_WIDTH'(w_key_db);
                IO_OFF_KEYEDGE: rd_data = DATA_BIT_WIDTH'(key_edge_q);
                default:        rd_data = '0;
            endcase
        end
    end

    assign hex0 = seg7_decode(hex_val_q[3:0]);
    assign hex1 = seg7_decode(hex_val_q[7:4]);
    assign hex2 = seg7_decode(hex_val_q[11:8]);
    assign hex3 = seg7_decode(hex_val_q[15:12]);
    assign ledr = ledr_q;
    assign ledg = ledg_q;

    // Address/data bits outside the decoded fields are intentionally ignored
    logic w_unused;
    assign w_unused = ^{addr[DATA_BIT_WIDTH-5:5], addr[1:0],
                        wr_data[DATA_BIT_WIDTH-1:16], w_sw_rise_nc};

endmodule
`default_nettype wire

// File: tb/tb_io_device_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_device_bank
//  Description : Directed self-checking bench for io_device_bank with
//                DEBOUNCE_CYCLES = 4. Pad-to-register latency follows the
//                IO_DEBOUNCE_EN build option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_device_bank;

    localparam int DW  = 32;
    localparam int DEB = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 1 + DEB;
`else
    localparam int LAT = 1;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] addr    = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic [9:0]    sw      = '0;
    logic [3:0]    key     = 4'hF;
    logic [6:0]    hex0, hex1, hex2, hex3;
    logic [9:0]    ledr;
    logic [7:0]    ledg;

    logic [27:0]   hex_bus;
    logic [DW-1:0] rv;
    int            checks   = 0;
    int            failures = 0;

    logic [6:0] seg_exp [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    assign hex_bus = {hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    io_device_bank #(
        .DATA_BIT_WIDTH  (DW),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .sw      (sw),
        .key     (key),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .ledr    (ledr),
        .ledg    (ledg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        addr    = '0;
    endtask

    task automatic rd(input logic [DW-1:0] a, output logic [DW-1:0] v);
        addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (hex_bus !== {4{7'b1000000}}) begin
            failures++; $display("FAIL %s_hex got=%h exp=%h", tag, hex_bus, {4{7'b1000000}});
        end
        checks++;
        if (ledr !== 10'h000) begin failures++; $display("FAIL %s_ledr got=%h exp=000", tag, ledr); end
        checks++;
        if (ledg !== 8'h00) begin failures++; $display("FAIL %s_ledg got=%h exp=00", tag, ledg); end
        rd(32'hF000_0018, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL %s_keyedge got=%h exp=0", tag, rv); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rd(32'hF000_0010, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL reset_sw got=%h exp=0", rv); end
        rd(32'hF000_0014, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL reset_key got=%h exp=0", rv); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_hex();
        logic [15:0] hv [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        wr(32'hF000_0000, 32'h0000_1234);
        checks++;
        if (hex_bus !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}) begin
            failures++; $display("FAIL hex_1234 got=%h exp=%h", hex_bus,
                                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        end
        rd(32'hF000_0003, rv);
        checks++;
        if (rv !== 32'h1234) begin failures++; $display("FAIL hex_read got=%h exp=1234", rv); end
        for (int i = 0; i < 4; i++) begin
            wr(32'hF000_0000, {16'h0, hv[i]});
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (hex_bus[7*n +: 7] !== seg_exp[hv[i][4*n +: 4]]) begin
                    failures++;
                    $display("FAIL hex_digit val=%h n=%0d got=%b exp=%b", hv[i], n,
                             hex_bus[7*n +: 7], seg_exp[hv[i][4*n +: 4]]);
                end
            end
        end
        rd(32'h0000_0000, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL unselected_read got=%h exp=0", rv); end
    endtask

    task automatic test_leds();
        wr(32'hF000_0004, 32'hFFFF_FFFF);
        wr(32'hF000_0008, 32'hFFFF_FFFF);
        checks++;
        if (ledr !== 10'h3FF) begin failures++; $display("FAIL ledr_set got=%h exp=3ff", ledr); end
        checks++;
        if (ledg !== 8'hFF) begin failures++; $display("FAIL ledg_set got=%h exp=ff", ledg); end
        rd(32'hF000_0004, rv);
        checks++;
        if (rv !== 32'h3FF) begin failures++; $display("FAIL ledr_read got=%h exp=3ff", rv); end
        rd(32'hF000_0008, rv);
        checks++;
        if (rv !== 32'hFF) begin failures++; $display("FAIL ledg_read got=%h exp=ff", rv); end
        wr(32'h0000_0004, 32'h0);
        wr(32'h0000_0008, 32'h0);
        wr(32'hF000_000C, 32'h0);
        checks++;
        if (ledr !== 10'h3FF) begin failures++; $display("FAIL ledr_unsel got=%h exp=3ff", ledr); end
        checks++;
        if (ledg !== 8'hFF) begin failures++; $display("FAIL ledg_unsel got=%h exp=ff", ledg); end
        wr(32'hF000_0004, 32'h0000_0155);
        wr(32'hF000_0008, 32'h0000_005A);
        checks++;
        if ({ledr, ledg} !== {10'h155, 8'h5A}) begin
            failures++; $display("FAIL led_pattern got=%h_%h exp=155_5a", ledr, ledg);
        end
        rd(32'hF000_000C, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL off3_read got=%h exp=0", rv); end
        rd(32'hF000_001C, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL off7_read got=%h exp=0", rv); end
    endtask

    task automatic test_sw_debounce();
        sw = 10'h2A5;
        for (int k = 0; k <= LAT; k++) begin
            tick();
            rd(32'hF000_0010, rv);
            checks++;
            if (rv !== ((k >= LAT) ? 32'h2A5 : 32'h0)) begin
                failures++; $display("FAIL sw_latency k=%0d got=%h exp=%h", k, rv,
                                     (k >= LAT) ? 32'h2A5 : 32'h0);
            end
        end
        sw = 10'h000;
        repeat (LAT + 1) tick();
        rd(32'hF000_0010, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL sw_release got=%h exp=0", rv); end
    endtask

    task automatic test_glitch();
`ifdef IO_DEBOUNCE_EN
        sw = 10'h0F0;
        repeat (3) tick();
        sw = 10'h000;
        for (int k = 0; k < LAT + 3; k++) begin
            tick();
            rd(32'hF000_0010, rv);
            checks++;
            if (rv !== 32'h0) begin failures++; $display("FAIL sw_glitch k=%0d got=%h exp=0", k, rv); end
        end
`else
        sw = 10'h0F0;
        tick();
        sw = 10'h000;
        tick();
        rd(32'hF000_0010, rv);
        checks++;
        if (rv !== 32'h0F0) begin failures++; $display("FAIL sw_pulse got=%h exp=0f0", rv); end
        tick();
        rd(32'hF000_0010, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL sw_pulse_end got=%h exp=0", rv); end
`endif
    endtask

    task automatic test_key_edge();
        key = 4'b1011;
        repeat (LAT) tick();
        rd(32'hF000_0014, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL key_early got=%h exp=0", rv); end
        tick();
        rd(32'hF000_0014, rv);
        checks++;
        if (rv !== 32'h4) begin failures++; $display("FAIL key_pressed got=%h exp=4", rv); end
        rd(32'hF000_0018, rv);
        checks++;
        if (rv !== 32'h4) begin failures++; $display("FAIL keyedge_set got=%h exp=4", rv); end
        key = 4'hF;
        repeat (LAT + 1) tick();
        rd(32'hF000_0014, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL key_released got=%h exp=0", rv); end
        rd(32'hF000_0018, rv);
        checks++;
        if (rv !== 32'h4) begin failures++; $display("FAIL keyedge_sticky got=%h exp=4", rv); end
        wr(32'hF000_0018, 32'h4);
        rd(32'hF000_0018, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL keyedge_w1c got=%h exp=0", rv); end
    endtask

    task automatic test_w1c_collision();
        key = 4'b1110;
        repeat (LAT) tick();
        // This write lands on the same edge key_db[0] rises
        wr(32'hF000_0018, 32'hF);
        rd(32'hF000_0018, rv);
        checks++;
        if (rv !== 32'h1) begin failures++; $display("FAIL w1c_collision got=%h exp=1", rv); end
        key = 4'hF;
        repeat (LAT + 1) tick();
        wr(32'hF000_0018, 32'h1);
        rd(32'hF000_0018, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL w1c_after got=%h exp=0", rv); end
    endtask

    task automatic test_reset_mid();
        wr(32'hF000_0000, 32'h0000_ABCD);
        wr(32'hF000_0004, 32'h0000_02AA);
        key = 4'b1101;
        repeat (LAT + 1) tick();
        rd(32'hF000_0018, rv);
        checks++;
        if (rv !== 32'h2) begin failures++; $display("FAIL mid_keyedge got=%h exp=2", rv); end
        sw = 10'h155;
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        rd(32'hF000_0010, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("FAIL mid_reset_sw got=%h exp=0", rv); end
        reset_n = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            tick();
            rd(32'hF000_0010, rv);
            checks++;
            if (rv !== ((k >= LAT) ? 32'h155 : 32'h0)) begin
                failures++; $display("FAIL post_reset_sw k=%0d got=%h exp=%h", k, rv,
                                     (k >= LAT) ? 32'h155 : 32'h0);
            end
        end
        rd(32'hF000_0014, rv);
        checks++;
        if (rv !== 32'h2) begin failures++; $display("FAIL post_reset_key got=%h exp=2", rv); end
        rd(32'hF000_0018, rv);
        checks++;
        if (rv !== 32'h2) begin failures++; $display("FAIL post_reset_keyedge got=%h exp=2", rv); end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_leds();
        test_sw_debounce();
        test_glitch();
        test_key_edge();
        test_w1c_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
